// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, data width, opcode legality check and sequencer state enum.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_INC = 4'b0010;
  localparam logic [OP_W-1:0] OP_DEC = 4'b0100;
  localparam logic [OP_W-1:0] OP_AND = 4'b1000;
  localparam logic [OP_W-1:0] OP_OR  = 4'b1001;
  localparam logic [OP_W-1:0] OP_NOT = 4'b1010;
  localparam logic [OP_W-1:0] OP_XOR = 4'b1100;
  localparam logic [OP_W-1:0] OP_SL  = 4'b1110;
  localparam logic [OP_W-1:0] OP_SR  = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_RESP
  } seq_state_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_AND,
      OP_OR, OP_NOT, OP_XOR, OP_SL, OP_SR: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 8-bit ALU; carry_out is carry for add/inc/sl, borrow for sub/dec, shifted-out bit for sr.
module alu
  import alu_pkg::*;
#(
  parameter int ALU_OP_W = 4,
  parameter int DATA_W   = 8
) (
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [ALU_OP_W-1:0] opcode,
  output logic [DATA_W-1:0]   result,
  output logic                carry_out
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide = '0;
    case (opcode)
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_INC:  wide = {1'b0, a} + (DATA_W+1)'(1);
      OP_DEC:  wide = {1'b0, a} - (DATA_W+1)'(1);
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_NOT:  wide = {1'b0, ~a};
      OP_XOR:  wide = {1'b0, a ^ b};
      OP_SL:   wide = {a, 1'b0};
      OP_SR:   wide = {a[0], 1'b0, a[DATA_W-1:1]};
      default: wide = '0;
    endcase
  end

  assign result    = wide[DATA_W-1:0];
  assign carry_out = wide[DATA_W];

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - command sequencer driving the shared alu from a 4-entry register file.
// Optional macro ALU_SEQ_FLAGS_EN adds registered rsp_zero/rsp_neg and internal Z/N flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int ALU_OP_W = 4,
  parameter int DATA_W   = 8,
  parameter int NREG     = 4,
  localparam int IDX_W   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_ld,
  input  logic [ALU_OP_W-1:0] cmd_op,
  input  logic [IDX_W-1:0]    cmd_dst,
  input  logic [IDX_W-1:0]    cmd_srca,
  input  logic [IDX_W-1:0]    cmd_srcb,
  input  logic [DATA_W-1:0]   cmd_imm,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_carry,
  output logic                rsp_err
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic                rsp_zero,
  output logic                rsp_neg
`endif
);

  seq_state_t state, state_nx;

  logic [DATA_W-1:0]   rf [NREG];
  logic                carry;
  logic [IDX_W-1:0]    dst_q, srca_q, srcb_q;
  logic [ALU_OP_W-1:0] op_q, alu_op;
  logic [DATA_W-1:0]   op_a, op_b, alu_result;
  logic                alu_carry;
  logic                accept, legal;

  assign accept    = cmd_valid & cmd_ready;
  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign legal     = is_legal_op(alu_op);

  alu #(.ALU_OP_W(ALU_OP_W), .DATA_W(DATA_W)) u_alu (
    .a         (op_a),
    .b         (op_b),
    .opcode    (alu_op),
    .result    (alu_result),
    .carry_out (alu_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (cmd_valid) state_nx = cmd_ld ? ST_RESP : ST_READ;
      ST_READ: state_nx = ST_EXEC;
      ST_EXEC: state_nx = ST_RESP;
      ST_RESP: if (rsp_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Response registers only change on load acceptance or in EXEC, so they hold through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      carry     <= 1'b0;
      dst_q     <= '0;
      srca_q    <= '0;
      srcb_q    <= '0;
      op_q      <= '0;
      alu_op    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            dst_q  <= cmd_dst;
            srca_q <= cmd_srca;
            srcb_q <= cmd_srcb;
            op_q   <= cmd_op;
            if (cmd_ld) begin
              rf[cmd_dst] <= cmd_imm;
              rsp_data    <= cmd_imm;
              rsp_carry   <= carry;
              rsp_err     <= 1'b0;
            end
          end
        end
        ST_READ: begin
          op_a   <= rf[srca_q];
          op_b   <= rf[srcb_q];
          alu_op <= op_q;
        end
        ST_EXEC: begin
          if (legal) begin
            rf[dst_q] <= alu_result;
            carry     <= alu_carry;
            rsp_data  <= alu_result;
            rsp_carry <= alu_carry;
            rsp_err   <= 1'b0;
          end else begin
            rsp_data  <= '0;
            rsp_carry <= carry;
            rsp_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic z_flag, n_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_flag   <= 1'b0;
      n_flag   <= 1'b0;
      rsp_zero <= 1'b0;
      rsp_neg  <= 1'b0;
    end else if (state == ST_IDLE && accept && cmd_ld) begin
      z_flag   <= (cmd_imm == '0);
      n_flag   <= cmd_imm[DATA_W-1];
      rsp_zero <= (cmd_imm == '0);
      rsp_neg  <= cmd_imm[DATA_W-1];
    end else if (state == ST_EXEC) begin
      // Illegal ops leave Z/N alone but the response flags still track rsp_data (forced 0).
      if (legal) begin
        z_flag   <= (alu_result == '0);
        n_flag   <= alu_result[DATA_W-1];
        rsp_zero <= (alu_result == '0);
        rsp_neg  <= alu_result[DATA_W-1];
      end else begin
        rsp_zero <= 1'b1;
        rsp_neg  <= 1'b0;
      end
    end
  end
`endif

endmodule
